alu_result_stage: RTL
=====================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter N, default 4: operand/result width in bits, shared with the upstream ALU.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  upstream presents op and the ten ALU results this cycle.
REQ-005 in_ready  output  1  stage can accept a new entry this cycle.
REQ-006 op  input  4  operation select: 0 SUM, 1 SUB, 2 MULT, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR, 8 SHR, 9 SHL.
REQ-007 rsum, rsub, rmult, rdiv, rmod, rand, ror, rxor, rshr, rshl  input  N each  ALU result buses.
REQ-008 out_valid  output  1  result, flags and op_q hold a valid entry.
REQ-009 out_ready  input  1  downstream consumes the entry this cycle.
REQ-010 result  output  N  registered selected result.
REQ-011 op_q  output  4  registered opcode of the held entry.
REQ-012 flag_z  output  1  registered zero flag of result.
REQ-013 flag_n  output  1  registered MSB (result[N-1]) of result.
REQ-014 flag_err  output  1  registered illegal-opcode flag.
REQ-015 op_count  output  8  number of entries accepted since reset, saturating.

Function
REQ-016 Stage SHALL be a one-entry output buffer with FSM states EMPTY and FULL.
REQ-017 in_ready SHALL equal (state==EMPTY) OR out_ready, combinationally.
REQ-018 out_valid SHALL be 1 exactly when state==FULL.
REQ-019 Accept SHALL occur when in_valid AND in_ready; consume SHALL occur when out_valid AND out_ready.
REQ-020 EMPTY + accept -> FULL, registers loaded; entry visible on out_valid one cycle after accept (latency 1).
REQ-021 FULL + consume, no accept -> EMPTY; result/flags/op_q keep last values.
REQ-022 FULL + consume + accept same cycle -> stay FULL, registers loaded with new entry (no bubble).
REQ-023 FULL + no consume -> stay FULL, all outputs stable regardless of in_valid, op or result buses.
REQ-024 On accept with op 0..9, result SHALL load the matching bus and flag_err SHALL load 0.
REQ-025 On accept with op 10..15, result SHALL load 0, flag_z 1, flag_n 0, flag_err 1.
REQ-026 flag_z SHALL load 1 iff the loaded result is all zeros; flag_n SHALL load bit N-1 of the loaded result.
REQ-027 op_q SHALL load op unmodified on every accept, including illegal opcodes.
REQ-028 op_count SHALL increment by 1 on every accept (legal or illegal) and hold at 255.
REQ-029 in_valid while in_ready=0 SHALL be ignored; upstream holds its inputs until accepted.
REQ-030 No output SHALL depend combinationally on the data inputs; only in_ready depends on out_ready.

Reset
REQ-031 With rst low: state EMPTY, out_valid 0, result 0, op_q 0, flag_z 0, flag_n 0, flag_err 0, op_count 0, asynchronously.
REQ-032 in_ready SHALL read 1 during reset.
REQ-033 Reset while FULL SHALL discard the entry; an accept coinciding with reset assertion SHALL NOT be registered.
REQ-034 First accept SHALL be possible on the first rising edge with rst high.

Verification
REQ-035 N=4, op=0, rsum=4'b0111, in_valid 1 one cycle, out_ready 0 -> next cycle out_valid 1, result 7, flag_z 0, flag_n 0, op_q 0, op_count 1; outputs held until out_ready.
REQ-036 op=1, rsub=4'b1101 -> result 13, flag_n 1, flag_z 0; op=5, rand=0 -> result 0, flag_z 1.
REQ-037 op=12, all buses 4'hF -> result 0, flag_z 1, flag_n 0, flag_err 1, op_q 12; next legal op clears flag_err.
REQ-038 FULL with out_ready 1 and in_valid 1 for 3 consecutive cycles (ops 6, 7, 8) -> out_valid stays 1, results update every cycle, op_count +3, in_ready stays 1.
REQ-039 FULL, out_ready 0, in_valid 1 with op 2 -> in_ready 0, outputs unchanged, op_count unchanged.
REQ-040 300 accepts -> op_count 255; rst low mid-FULL -> out_valid 0 and all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_result_stage.sv
// One-entry registered output buffer that selects the ALU result for the
// requested operation, derives flags, and counts accepted entries.
// The AND bus is named r_and because "rand" is a reserved word in SystemVerilog.
module alu_result_stage #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   op,
   input  logic [N-1:0] rsum,
   input  logic [N-1:0] rsub,
   input  logic [N-1:0] rmult,
   input  logic [N-1:0] rdiv,
   input  logic [N-1:0] rmod,
   input  logic [N-1:0] r_and,
   input  logic [N-1:0] ror,
   input  logic [N-1:0] rxor,
   input  logic [N-1:0] rshr,
   input  logic [N-1:0] rshl,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic [3:0]   op_q,
   output logic         flag_z,
   output logic         flag_n,
   output logic         flag_err,
   output logic [7:0]   op_count
);

   typedef enum logic {
      EMPTY,
      FULL
   } state_t;

   state_t       state;
   state_t       next_state;
   logic         accept;
   logic [N-1:0] sel_result;
   logic         sel_err;

   // A held entry can be replaced in the same cycle it drains, so there is no bubble.
   assign in_ready  = (state == EMPTY) || out_ready;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == FULL);

   always_comb begin
      sel_result = '0;
      sel_err    = 1'b0;
      case (op)
         4'd0:    sel_result = rsum;
         4'd1:    sel_result = rsub;
         4'd2:    sel_result = rmult;
         4'd3:    sel_result = rdiv;
         4'd4:    sel_result = rmod;
         4'd5:    sel_result = r_and;
         4'd6:    sel_result = ror;
         4'd7:    sel_result = rxor;
         4'd8:    sel_result = rshr;
         4'd9:    sel_result = rshl;
         default: sel_err    = 1'b1;
      endcase
   end

   always_comb begin
      next_state = state;
      case (state)
         EMPTY:   if (accept) next_state = FULL;
         FULL:    if (out_ready && !accept) next_state = EMPTY;
         default: next_state = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= EMPTY;
      end else begin
         state <= next_state;
      end
   end

   // Payload registers only move on accept; draining leaves the last entry visible.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result   <= '0;
         op_q     <= '0;
         flag_z   <= 1'b0;
         flag_n   <= 1'b0;
         flag_err <= 1'b0;
      end else if (accept) begin
         result   <= sel_result;
         op_q     <= op;
         flag_z   <= (sel_result == '0);
         flag_n   <= sel_result[N-1];
         flag_err <= sel_err;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_count <= '0;
      end else if (accept && (op_count != 8'hFF)) begin
         op_count <= op_count + 8'd1;
      end
   end

endmodule
